// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store bus sequencer with extension, strobes and stall control
// One bus transaction per memory instruction; a response under ext_stall is parked in HOLD until retire.
module mem_access_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  input  logic            op_load,
  input  logic            op_store,
  input  logic [1:0]      op_size,
  input  logic            op_unsigned,
  input  logic [XLEN-1:0] op_addr,
  input  logic [XLEN-1:0] op_wdata,
  input  logic            ext_stall,
  output logic            dreq_valid,
  output logic            dreq_write,
  output logic [XLEN-1:0] dreq_addr,
  output logic [1:0]      dreq_size,
  output logic [7:0]      dreq_strobe,
  output logic [XLEN-1:0] dreq_wdata,
  input  logic            dresp_ok,
  input  logic [XLEN-1:0] dresp_rdata,
  output logic            mem_stall,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_rdata,
  output logic            misalign
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t          state;
  logic            lat_store;
  logic [1:0]      lat_size;
  logic            lat_unsigned;
  logic [XLEN-1:0] lat_addr;
  logic [XLEN-1:0] lat_wdata;
  logic [XLEN-1:0] held_rdata;

  logic            misaligned;
  logic            mem_op;
  logic            cur_store;
  logic [1:0]      cur_size;
  logic            cur_unsigned;
  logic [XLEN-1:0] cur_addr;
  logic [XLEN-1:0] cur_wdata;
  logic [XLEN-1:0] ext_data;
  logic [15:0]     strobe_wide;

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] rdata, input logic [2:0] off,
                                             input logic [1:0] size, input logic uns);
    logic [XLEN-1:0] s;
    s = rdata >> {off, 3'b000};
    case (size)
      2'd0:    extend = {{(XLEN-8){~uns & s[7]}}, s[7:0]};
      2'd1:    extend = {{(XLEN-16){~uns & s[15]}}, s[15:0]};
      2'd2:    extend = {{(XLEN-32){~uns & s[31]}}, s[31:0]};
      default: extend = s;
    endcase
  endfunction

  function automatic logic [2:0] align_mask(input logic [1:0] size);
    align_mask = 3'((4'd1 << size) - 4'd1);
  endfunction

  function automatic logic [7:0] byte_mask(input logic [1:0] size);
    byte_mask = 8'((9'd1 << (4'd1 << size)) - 9'd1);
  endfunction

  assign misaligned = op_valid & (op_load | op_store) & (|(op_addr[2:0] & align_mask(op_size)));
  assign mem_op     = op_valid & (op_load | op_store) & ~misaligned;

  // Once a request is outstanding the bus sees the captured fields, not the live EX/MEM inputs.
  assign cur_store    = (state == IDLE) ? op_store    : lat_store;
  assign cur_size     = (state == IDLE) ? op_size     : lat_size;
  assign cur_unsigned = (state == IDLE) ? op_unsigned : lat_unsigned;
  assign cur_addr     = (state == IDLE) ? op_addr     : lat_addr;
  assign cur_wdata    = (state == IDLE) ? op_wdata    : lat_wdata;

  assign ext_data    = cur_store ? '0 : extend(dresp_rdata, cur_addr[2:0], cur_size, cur_unsigned);
  assign strobe_wide = {8'h00, byte_mask(cur_size)} << cur_addr[2:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      lat_store    <= 1'b0;
      lat_size     <= 2'd0;
      lat_unsigned <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      held_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            lat_store    <= op_store;
            lat_size     <= op_size;
            lat_unsigned <= op_unsigned;
            lat_addr     <= op_addr;
            lat_wdata    <= op_wdata;
            if (!dresp_ok) begin
              state <= WAIT;
            end else if (ext_stall) begin
              held_rdata <= ext_data;
              state      <= HOLD;
            end
          end
        end
        WAIT: begin
          if (dresp_ok) begin
            if (ext_stall) begin
              held_rdata <= ext_data;
              state      <= HOLD;
            end else begin
              state <= IDLE;
            end
          end
        end
        HOLD: begin
          if (!ext_stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    dreq_valid  = 1'b0;
    dreq_write  = 1'b0;
    dreq_addr   = '0;
    dreq_size   = 2'd0;
    dreq_strobe = 8'h00;
    dreq_wdata  = '0;
    mem_stall   = 1'b0;
    wb_valid    = 1'b0;
    wb_rdata    = '0;
    misalign    = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          misalign = misaligned;
          if (mem_op) begin
            dreq_valid = 1'b1;
            if (dresp_ok) begin
              wb_valid = 1'b1;
              wb_rdata = ext_data;
            end else begin
              mem_stall = 1'b1;
            end
          end else begin
            wb_valid = op_valid;
          end
        end
        WAIT: begin
          dreq_valid = 1'b1;
          if (dresp_ok) begin
            wb_valid = 1'b1;
            wb_rdata = ext_data;
          end else begin
            mem_stall = 1'b1;
          end
        end
        HOLD: begin
          wb_valid = 1'b1;
          wb_rdata = held_rdata;
        end
        default: ;
      endcase
      if (dreq_valid) begin
        dreq_write  = cur_store;
        dreq_addr   = cur_addr;
        dreq_size   = cur_size;
        dreq_strobe = cur_store ? strobe_wide[7:0] : 8'h00;
        dreq_wdata  = cur_wdata << {cur_addr[2:0], 3'b000};
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;

  typedef struct packed {
    logic        write;
    logic [63:0] addr;
    logic [1:0]  size;
    logic [7:0]  strobe;
    logic [63:0] wdata;
  } req_t;

  logic        clk, reset;
  logic        op_valid, op_load, op_store, op_unsigned, ext_stall;
  logic [1:0]  op_size;
  logic [63:0] op_addr, op_wdata;
  logic        dreq_valid, dreq_write;
  logic [63:0] dreq_addr, dreq_wdata;
  logic [1:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic        dresp_ok;
  logic [63:0] dresp_rdata;
  logic        mem_stall, wb_valid, misalign;
  logic [63:0] wb_rdata;

  int checks = 0;
  int errors = 0;
  req_t        exp_req[$];
  logic [63:0] exp_wb[$];
  logic        prev_valid = 1'b0;
  logic        prev_done  = 1'b0;

  mem_access_ctrl #(.XLEN(64)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_load(op_load), .op_store(op_store), .op_size(op_size),
    .op_unsigned(op_unsigned), .op_addr(op_addr), .op_wdata(op_wdata), .ext_stall(ext_stall),
    .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_wdata(dreq_wdata),
    .dresp_ok(dresp_ok), .dresp_rdata(dresp_rdata),
    .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_rdata(wb_rdata), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // A retire is the MEM/WB register actually capturing: valid while the pipeline advances.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid <= 1'b0;
      prev_done  <= 1'b0;
    end else begin
      if (wb_valid && !mem_stall && !ext_stall) begin
        if (exp_wb.size() == 0) check("wb_unexpected", 1, 0);
        else check("wb_rdata", wb_rdata, exp_wb.pop_front());
      end
      if (dreq_valid && (!prev_valid || prev_done)) begin
        if (exp_req.size() == 0) check("req_unexpected", 1, 0);
        else check("req_fields", {dreq_write, dreq_addr, dreq_size, dreq_strobe, dreq_wdata},
                   exp_req.pop_front());
      end
      prev_valid <= dreq_valid;
      prev_done  <= dreq_valid & dresp_ok;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wd);
    op_valid = 1'b1; op_load = ld; op_store = st; op_size = sz;
    op_unsigned = uns; op_addr = addr; op_wdata = wd;
  endtask

  task automatic clear_op();
    op_valid = 1'b0; op_load = 1'b0; op_store = 1'b0; op_size = 2'd0;
    op_unsigned = 1'b0; op_addr = '0; op_wdata = '0; dresp_ok = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ext_stall = 1'b0; dresp_rdata = '0;
    clear_op();
    next_cycle();
    @(negedge clk);
    check("reset_dreq_valid", dreq_valid, 0);
    check("reset_wb_valid", wb_valid, 0);
    next_cycle();
    reset = 1'b0;

    // Load word, 3-cycle latency, sign-extended upper half of the beat.
    set_op(1, 0, 2'd2, 0, 64'h1004, 64'h0);
    dresp_rdata = 64'h8000_0001_0000_0000;
    exp_req.push_back('{1'b0, 64'h1004, 2'd2, 8'h00, 64'h0});
    exp_wb.push_back(64'hFFFF_FFFF_8000_0001);
    for (int k = 0; k < 3; k++) begin
      dresp_ok = (k == 2);
      @(negedge clk);
      check($sformatf("lw_dreq_valid_%0d", k), dreq_valid, 1);
      check($sformatf("lw_mem_stall_%0d", k), mem_stall, (k < 2) ? 1 : 0);
      next_cycle();
    end
    clear_op();
    @(negedge clk);
    check("lw_dreq_done", dreq_valid, 0);
    next_cycle();

    // Store half, zero-wait response.
    set_op(0, 1, 2'd1, 0, 64'h2006, 64'hABCD);
    dresp_ok = 1'b1;
    exp_req.push_back('{1'b1, 64'h2006, 2'd1, 8'hC0, 64'hABCD_0000_0000_0000});
    exp_wb.push_back(64'h0);
    @(negedge clk);
    check("sh_strobe", dreq_strobe, 8'hC0);
    check("sh_wdata", dreq_wdata, 64'hABCD_0000_0000_0000);
    check("sh_mem_stall", mem_stall, 0);
    next_cycle();
    clear_op();
    @(negedge clk);
    check("sh_one_cycle", dreq_valid, 0);
    next_cycle();

    // Load byte unsigned; response lands under ext_stall and is held.
    set_op(1, 0, 2'd0, 1, 64'h7, 64'h0);
    dresp_rdata = 64'hF100_0000_0000_0000;
    exp_req.push_back('{1'b0, 64'h7, 2'd0, 8'h00, 64'h0});
    exp_wb.push_back(64'hF1);
    next_cycle();
    dresp_ok = 1'b1; ext_stall = 1'b1;
    @(negedge clk);
    check("lbu_resp_stall", mem_stall, 0);
    next_cycle();
    dresp_ok = 1'b0; dresp_rdata = 64'h5555_5555_5555_5555;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("hold_dreq_%0d", k), dreq_valid, 0);
      check($sformatf("hold_rdata_%0d", k), wb_rdata, 64'hF1);
      check($sformatf("hold_wb_valid_%0d", k), wb_valid, 1);
      next_cycle();
    end
    ext_stall = 1'b0;
    @(negedge clk);
    check("hold_release_dreq", dreq_valid, 0);
    next_cycle();
    clear_op();
    next_cycle();

    // Misaligned accesses issue nothing and retire with zero data.
    set_op(1, 0, 2'd3, 0, 64'h1003, 64'h0);
    exp_wb.push_back(64'h0);
    @(negedge clk);
    check("mis_d_misalign", misalign, 1);
    check("mis_d_dreq", dreq_valid, 0);
    check("mis_d_stall", mem_stall, 0);
    next_cycle();
    set_op(1, 0, 2'd1, 0, 64'h1001, 64'h0);
    exp_wb.push_back(64'h0);
    @(negedge clk);
    check("mis_h_misalign", misalign, 1);
    next_cycle();
    set_op(1, 0, 2'd0, 0, 64'h1003, 64'h0);
    dresp_ok = 1'b1; dresp_rdata = 64'h0000_0000_8000_0000;
    exp_req.push_back('{1'b0, 64'h1003, 2'd0, 8'h00, 64'h0});
    exp_wb.push_back(64'hFFFF_FFFF_FFFF_FF80);
    @(negedge clk);
    check("byte_aligned_misalign", misalign, 0);
    next_cycle();
    clear_op();
    next_cycle();

    // Reset while a request is outstanding; the late response is dropped.
    set_op(1, 0, 2'd2, 0, 64'h3000, 64'h0);
    exp_req.push_back('{1'b0, 64'h3000, 2'd2, 8'h00, 64'h0});
    next_cycle();
    @(negedge clk);
    check("rst_wait_stall", mem_stall, 1);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check("rst_outputs", {dreq_valid, dreq_write, dreq_addr, dreq_size, dreq_strobe, dreq_wdata,
                          mem_stall, wb_valid, wb_rdata, misalign}, 0);
    next_cycle();
    reset = 1'b0;
    clear_op();
    dresp_ok = 1'b1; dresp_rdata = 64'h1234;
    @(negedge clk);
    check("late_resp_wb_valid", wb_valid, 0);
    check("late_resp_dreq", dreq_valid, 0);
    next_cycle();
    dresp_ok = 1'b0;
    next_cycle();

    // Back-to-back loads, one wait cycle each.
    set_op(1, 0, 2'd3, 0, 64'h0, 64'h0);
    dresp_rdata = 64'h1122_3344_5566_7788;
    exp_req.push_back('{1'b0, 64'h0, 2'd3, 8'h00, 64'h0});
    exp_wb.push_back(64'h1122_3344_5566_7788);
    @(negedge clk);
    check("b2b_dreq_0", dreq_valid, 1);
    next_cycle();
    dresp_ok = 1'b1;
    @(negedge clk);
    check("b2b_dreq_1", dreq_valid, 1);
    next_cycle();
    set_op(1, 0, 2'd1, 0, 64'h8, 64'h0);
    dresp_ok = 1'b0; dresp_rdata = 64'h0000_0000_0000_8001;
    exp_req.push_back('{1'b0, 64'h8, 2'd1, 8'h00, 64'h0});
    exp_wb.push_back(64'hFFFF_FFFF_FFFF_8001);
    @(negedge clk);
    check("b2b_dreq_2", dreq_valid, 1);
    next_cycle();
    dresp_ok = 1'b1;
    @(negedge clk);
    check("b2b_dreq_3", dreq_valid, 1);
    next_cycle();
    clear_op();
    next_cycle();
    next_cycle();

    check("req_queue_drained", exp_req.size(), 0);
    check("wb_queue_drained", exp_wb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
